// File: rtl/sha256_port_responder_if.sv
// Request/response and hash-core bundle for one SHA-256 port responder.
// The slave modport is the responder side; master is the requester/core side.
interface sha256_port_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int CMD_WIDTH  = 4
);
  logic [CMD_WIDTH-1:0]    req_cmd_in;
  logic [DATA_WIDTH-1:0]   req_data_in;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [RESP_WIDTH-1:0]   out_resp;
  logic                    core_start;
  logic                    core_init;
  logic [16*DATA_WIDTH-1:0] core_block;
  logic                    core_ready;
  logic                    core_done;
  logic [8*DATA_WIDTH-1:0] core_digest;

  modport master (
    output req_cmd_in, req_data_in,
    output core_ready, core_done, core_digest,
    input  out_data, out_resp,
    input  core_start, core_init, core_block
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    input  core_ready, core_done, core_digest,
    output out_data, out_resp,
    output core_start, core_init, core_block
  );
endinterface

// File: rtl/sha256_port_responder.sv
// SHA-256 request port responder: block assembly, core handoff, digest reads.
// Define SHA256_PORT_CLR_EN to enable command 4 (CLEAR).
module sha256_port_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int CMD_WIDTH  = 4
) (
  input logic clk,
  input logic rst,
  sha256_port_responder_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [RESP_WIDTH-1:0] R_OK   = RESP_WIDTH'(1);
  localparam logic [RESP_WIDTH-1:0] R_ERR  = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] R_BUSY = RESP_WIDTH'(3);

  state_t state_q, state_d;
  logic [4:0] wptr_q, wptr_d;
  logic [2:0] rptr_q, rptr_d;
  logic       dv_q, dv_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [RESP_WIDTH-1:0] resp_q, resp_d;
  logic start_q, start_d;
  logic init_q, init_d;
  logic blk_we, dig_we, clr;

  logic [DATA_WIDTH-1:0] blk_q [16];
  logic [DATA_WIDTH-1:0] dig_q [8];
  logic [16*DATA_WIDTH-1:0] blk_flat;

  logic is_nop, is_load, is_start, is_read, is_clr, is_bad;
  logic wfull;

  assign is_nop   = bus.req_cmd_in == CMD_WIDTH'(0);
  assign is_load  = bus.req_cmd_in == CMD_WIDTH'(1);
  assign is_start = bus.req_cmd_in == CMD_WIDTH'(2);
  assign is_read  = bus.req_cmd_in == CMD_WIDTH'(3);
`ifdef SHA256_PORT_CLR_EN
  assign is_clr   = bus.req_cmd_in == CMD_WIDTH'(4);
`else
  assign is_clr   = 1'b0;
`endif
  assign is_bad = !(is_nop | is_load | is_start | is_read | is_clr);
  assign wfull  = wptr_q == 5'd16;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dv_d    = dv_q;
    data_d  = '0;
    resp_d  = '0;
    start_d = 1'b0;
    init_d  = 1'b0;
    blk_we  = 1'b0;
    dig_we  = 1'b0;
    clr     = 1'b0;
    if (state_q == BUSY) begin
      if (!is_nop)
        resp_d = is_bad ? R_ERR : R_BUSY;
      if (bus.core_done) begin
        dig_we  = 1'b1;
        dv_d    = 1'b1;
        wptr_d  = '0;
        rptr_d  = '0;
        state_d = IDLE;
      end
    end else begin
      unique case (1'b1)
        is_load: begin
          if (!wfull) begin
            blk_we = 1'b1;
            data_d = DATA_WIDTH'(wptr_q);
            wptr_d = wptr_q + 5'd1;
            resp_d = R_OK;
          end else begin
            resp_d = R_ERR;
          end
        end
        is_start: begin
          if (!wfull) begin
            resp_d = R_ERR;
          end else if (!bus.core_ready) begin
            resp_d = R_BUSY;
          end else begin
            start_d = 1'b1;
            init_d  = bus.req_data_in[0];
            dv_d    = 1'b0;
            resp_d  = R_OK;
            state_d = BUSY;
          end
        end
        is_read: begin
          if (!dv_q) begin
            resp_d = R_ERR;
          end else begin
            data_d = dig_q[rptr_q];
            rptr_d = rptr_q + 3'd1;
            resp_d = R_OK;
          end
        end
        is_clr: begin
          clr    = 1'b1;
          wptr_d = '0;
          rptr_d = '0;
          dv_d   = 1'b0;
          resp_d = R_OK;
        end
        is_bad: resp_d = R_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      resp_q  <= '0;
      start_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      start_q <= start_d;
      init_q  <= init_d;
    end
  end

  // H0 sits in the top word of core_digest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      for (int i = 0; i < 8; i++)  dig_q[i] <= '0;
    end else begin
      if (clr) begin
        for (int i = 0; i < 16; i++) blk_q[i] <= '0;
        for (int i = 0; i < 8; i++)  dig_q[i] <= '0;
      end
      if (blk_we)
        blk_q[wptr_q[3:0]] <= bus.req_data_in;
      if (dig_we)
        for (int i = 0; i < 8; i++)
          dig_q[i] <= bus.core_digest[(8-i)*DATA_WIDTH-1 -: DATA_WIDTH];
    end
  end

  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < 16; i++)
      blk_flat[(16-i)*DATA_WIDTH-1 -: DATA_WIDTH] = blk_q[i];
  end

  assign bus.out_data   = data_q;
  assign bus.out_resp   = resp_q;
  assign bus.core_start = start_q;
  assign bus.core_init  = init_q;
  assign bus.core_block = blk_flat;
endmodule

// File: tb/tb_sha256_port_responder.sv
// Randomized bench for sha256_port_responder against a behavioural model.
// Honours SHA256_PORT_CLR_EN the same way as the design.
module tb_sha256_port_responder;
  typedef struct packed {
    logic [1:0]   resp;
    logic [31:0]  data;
    logic         start;
    logic         init;
    logic [511:0] block;
  } exp_t;

`ifdef SHA256_PORT_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_port_responder_if ifc ();

  sha256_port_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  bit          m_busy;
  bit          m_dv;
  int          m_wptr;
  int          m_rptr;
  logic [31:0] m_blk [16];
  logic [31:0] m_dig [8];
  exp_t        nxt = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0]  abc [16];
  logic [255:0] abc_dig =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  task automatic chk(input string name, input logic [511:0] got,
                     input logic [511:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_dv   = 0;
    m_wptr = 0;
    m_rptr = 0;
    for (int i = 0; i < 16; i++) m_blk[i] = '0;
    for (int i = 0; i < 8; i++)  m_dig[i] = '0;
  endtask

  // One command cycle: drive inputs and predict the next-cycle outputs
  task automatic step(input logic [3:0] cmd, input logic [31:0] data,
                      input bit ready = 1'b1, input bit done = 1'b0,
                      input logic [255:0] dig = '0);
    exp_t e;
    @(negedge clk);
    ifc.req_cmd_in  = cmd;
    ifc.req_data_in = data;
    ifc.core_ready  = ready;
    ifc.core_done   = done;
    ifc.core_digest = dig;
    e = '0;
    if (m_busy) begin
      if (cmd != 0)
        e.resp = (cmd <= 3 || (CLR_EN && cmd == 4)) ? 2'd3 : 2'd2;
      if (done) begin
        for (int i = 0; i < 8; i++) m_dig[i] = dig[255-32*i -: 32];
        m_dv = 1; m_wptr = 0; m_rptr = 0; m_busy = 0;
      end
    end else begin
      case (cmd)
        4'd0: ;
        4'd1:
          if (m_wptr < 16) begin
            m_blk[m_wptr] = data;
            e.data = 32'(m_wptr);
            e.resp = 2'd1;
            m_wptr++;
          end else e.resp = 2'd2;
        4'd2:
          if (m_wptr < 16) e.resp = 2'd2;
          else if (!ready) e.resp = 2'd3;
          else begin
            e.resp = 2'd1; e.start = 1; e.init = data[0];
            m_dv = 0; m_busy = 1;
          end
        4'd3:
          if (!m_dv) e.resp = 2'd2;
          else begin
            e.resp = 2'd1;
            e.data = m_dig[m_rptr];
            m_rptr = (m_rptr + 1) % 8;
          end
        4'd4:
          if (CLR_EN) begin
            model_reset();
            e.resp = 2'd1;
          end else e.resp = 2'd2;
        default: e.resp = 2'd2;
      endcase
    end
    for (int i = 0; i < 16; i++) e.block[511-32*i -: 32] = m_blk[i];
    nxt = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifc.req_cmd_in = '0;
    ifc.core_done  = 1'b0;
    model_reset();
    nxt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      e = nxt;
      #1;
      chk("resp", 512'(ifc.out_resp), 512'(e.resp));
      chk("data", 512'(ifc.out_data), 512'(e.data));
      chk("start", 512'(ifc.core_start), 512'(e.start));
      chk("init", 512'(ifc.core_init), 512'(e.init));
      chk("block", ifc.core_block, e.block);
    end
  end

  initial begin
    logic [3:0] c;
    int r;
    for (int i = 0; i < 16; i++) abc[i] = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    ifc.req_cmd_in  = '0;
    ifc.req_data_in = '0;
    ifc.core_ready  = 1'b1;
    ifc.core_done   = 1'b0;
    ifc.core_digest = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    post();
    chk("lit_rst_resp", 512'(ifc.out_resp), 512'd0);
    chk("lit_rst_block", ifc.core_block, 512'd0);

    step(4'd3, 32'd0); post();
    chk("lit_read_nodig", 512'(ifc.out_resp), 512'd2);
    step(4'd1, 32'hDEADBEEF); post();
    chk("lit_load0_resp", 512'(ifc.out_resp), 512'd1);
    chk("lit_load0_idx", 512'(ifc.out_data), 512'd0);
    step(4'd1, 32'h11111111); post();
    chk("lit_load1_idx", 512'(ifc.out_data), 512'd1);
    for (int i = 0; i < 3; i++) step(4'd1, $urandom);
    step(4'd4, 32'd0); post();
    chk("lit_cmd4", 512'(ifc.out_resp), CLR_EN ? 512'd1 : 512'd2);
    step(4'd1, 32'h5); post();
    chk("lit_cmd4_next", 512'(ifc.out_data), CLR_EN ? 512'd0 : 512'd5);

    do_reset();
    for (int i = 0; i < 15; i++) step(4'd1, abc[i]);
    step(4'd2, 32'd1); post();
    chk("lit_start15", 512'(ifc.out_resp), 512'd2);
    chk("lit_start15_pulse", 512'(ifc.core_start), 512'd0);
    step(4'd1, abc[15]); post();
    chk("lit_load15_idx", 512'(ifc.out_data), 512'd15);
    step(4'd1, 32'h12345678); post();
    chk("lit_load17", 512'(ifc.out_resp), 512'd2);
    chk("lit_buf15", 512'(ifc.core_block[31:0]), 512'h18);
    step(4'd2, 32'd1, 1'b0); post();
    chk("lit_start_notready", 512'(ifc.out_resp), 512'd3);
    step(4'd2, 32'd1); post();
    chk("lit_start_resp", 512'(ifc.out_resp), 512'd1);
    chk("lit_start_pulse", 512'(ifc.core_start), 512'd1);
    chk("lit_start_init", 512'(ifc.core_init), 512'd1);
    step(4'd1, 32'd7); post();
    chk("lit_busy_load", 512'(ifc.out_resp), 512'd3);
    chk("lit_start_gone", 512'(ifc.core_start), 512'd0);
    step(4'd2, 32'd1);
    step(4'd3, 32'd0);
    step(4'd1, 32'd9, 1'b1, 1'b1, abc_dig); post();
    chk("lit_busy_done", 512'(ifc.out_resp), 512'd3);
    for (int i = 0; i < 9; i++) begin
      step(4'd3, 32'd0); post();
      if (i == 0 || i == 8)
        chk("lit_read_h0", 512'(ifc.out_data), 512'hBA7816BF);
      if (i == 7)
        chk("lit_read_h7", 512'(ifc.out_data), 512'hF20015AD);
    end

    for (int i = 0; i < 16; i++) step(4'd1, $urandom);
    step(4'd2, 32'd0); post();
    chk("lit_start_init0", 512'(ifc.core_init), 512'd0);
    step(4'd0, 32'd0);
    do_reset();
    post();
    chk("lit_midrst_resp", 512'(ifc.out_resp), 512'd0);
    step(4'd0, 32'd0, 1'b1, 1'b1, abc_dig);
    step(4'd3, 32'd0); post();
    chk("lit_midrst_read", 512'(ifc.out_resp), 512'd2);

    repeat (3000) begin
      r = $urandom_range(0, 15);
      if (r < 2 || r == 15) c = 4'd0;
      else if (r < 8)  c = 4'd1;
      else if (r < 10) c = 4'd2;
      else if (r < 13) c = 4'd3;
      else if (r == 13) c = 4'd4;
      else c = 4'($urandom_range(5, 15));
      step(c, $urandom, $urandom_range(0, 3) != 0,
           m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0),
           {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom});
    end
    step(4'd0, 32'd0);
    post();
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sha256_port_responder.md
# sha256_port_responder

DUT-side responder for one SHA-256 request port: accepts one-cycle commands on `req_cmd_in`/`req_data_in`, assembles a 16-word message block, hands it to the hash core, and returns status and digest words on `out_data`/`out_resp`. One instance sits in front of the shared core per request port. Every accepted command produces exactly one response cycle.

## Interface
- DATA_WIDTH, 32, command/response data word width.
- RESP_WIDTH, 2, response code width.
- CMD_WIDTH, 4, command code width.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_cmd_in  in  CMD_WIDTH  command; nonzero for one cycle = request.
- req_data_in  in  DATA_WIDTH  command operand, sampled with cmd.
- out_data  out  DATA_WIDTH  response payload; 0 when out_resp = 0.
- out_resp  out  RESP_WIDTH  0 = none, 1 = OK, 2 = error, 3 = busy.
- core_start  out  1  one-cycle start pulse to hash core.
- core_init  out  1  valid with core_start; 1 = first block (load IV), 0 = continue chain.
- core_block  out  512  assembled block; word i at [511-32i -: 32].
- core_ready  in  1  core can accept a start.
- core_done  in  1  one-cycle pulse; core_digest valid this cycle.
- core_digest  in  256  H0..H7, H0 at [255:224].

## Operation
- State: IDLE, BUSY. Registers: wptr (0..16), rptr (0..7), dig_valid, 16x32 block buffer, 8x32 digest buffer.
- Commands (from state at sample edge):
  - 0 NOP: no response.
  - 1 LOAD: IDLE and wptr<16 → buf[wptr]=data, wptr++, resp 1, out_data = index written. IDLE and wptr=16 → resp 2, no write. BUSY → resp 3.
  - 2 START: IDLE, wptr=16, core_ready=1 → core_start pulse, core_init=data[0], dig_valid=0, resp 1, out_data=0, → BUSY. IDLE, wptr<16 → resp 2. IDLE, core_ready=0 → resp 3. BUSY → resp 3.
  - 3 READ: BUSY → resp 3. IDLE, dig_valid=0 → resp 2. IDLE, dig_valid=1 → out_data = digest[rptr], resp 1, rptr = (rptr+1) mod 8 (wraps H7→H0).
  - any other code → resp 2, no state change.
- BUSY with core_done=1 → latch digest, dig_valid=1, wptr=0, rptr=0, → IDLE. core_done in IDLE ignored.
- Block buffer contents unchanged by START; new LOADs overwrite from index 0.

## Timing
- Reset: state IDLE; wptr, rptr, dig_valid = 0; out_data, out_resp, core_start, core_init = 0; core_block = 0.
- Response latency: exactly 1 cycle after the cmd sample edge; out_resp nonzero for one cycle only.
- Back-to-back commands every cycle allowed; each gets its own response on the following cycle.
- core_start registered, high exactly one cycle, coincident with START's OK response; core_init held with it.
- core_block is the buffer output, stable from START until the next LOAD.
- Simultaneous core_done and command in BUSY: command answered busy (3); digest latched same edge; next-cycle READ returns H0.
- Reset mid-BUSY: drop to IDLE immediately; a later core_done is ignored; no response pending.

## Configuration
- SHA256_PORT_CLR_EN defined: cmd 4 CLEAR. IDLE → wptr, rptr, dig_valid = 0, buffers zeroed, resp 1. BUSY → resp 3.
- Undefined: cmd 4 is invalid → resp 2, no state change.

## Test plan
- Reset then READ → resp 2; LOAD data 0xDEADBEEF → resp 1, out_data 0; second LOAD → out_data 1.
- 16 LOADs of "abc" padded block, START data 1 → core_start/core_init high one cycle, resp 1; model core_done with digest ba7816bf…f20015ad; 9 READs → H0..H7 then 0xBA7816BF again (wrap).
- START after 15 LOADs → resp 2, no core_start; 17th LOAD after 16 → resp 2, buf[15] unchanged.
- During BUSY: LOAD, START, READ each → resp 3; command on same cycle as core_done → resp 3, next READ → H0.
- Assert rst during BUSY → all outputs 0 next cycle; subsequent core_done ignored; READ → resp 2.
- cmd 4 in IDLE with 5 words loaded: with SHA256_PORT_CLR_EN → resp 1, next LOAD index 0; without → resp 2, next LOAD index 5.
